// File: rtl/spi_bus_arbiter.sv
// Two-port frame arbiter in front of the fifo2spi bridge: round-robin whole-frame grants,
// stream muxing and a minimum CS-high gap. Define SPI_ARB_TIMEOUT_EN to add a frame timeout.
module spi_bus_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          m0_wr_valid,
  input  logic [DW-1:0] m0_wr_data,
  output logic          m0_wr_ready,
  output logic          m0_rd_valid,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m0_rd_ready,
  output logic          gnt0,
  input  logic          req1,
  input  logic          m1_wr_valid,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m1_wr_ready,
  output logic          m1_rd_valid,
  output logic [DW-1:0] m1_rd_data,
  input  logic          m1_rd_ready,
  output logic          gnt1,
  output logic          br_cs,
  output logic          br_wr_valid,
  output logic [DW-1:0] br_wr_data,
  input  logic          br_wr_ready,
  input  logic          br_rd_valid,
  input  logic [DW-1:0] br_rd_data,
  output logic          br_rd_ready,
  input  logic          br_busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {StIdle, StOwn, StDrain, StGap} state_e;

  localparam logic [7:0] GapInit = 8'(CS_GAP);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] gap_q, gap_d;
  logic [1:0] req, elig;
  logic       win;

  assign req = {req1, req0};

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [15:0] frame_q, frame_d;
  logic [1:0]  block_q, block_d;
  logic        terr_q, terr_d;

  // A port that timed out stays locked out until its req drops.
  assign elig        = req & ~block_q;
  assign timeout_err = terr_q;
`else
  assign elig        = req;
  assign timeout_err = 1'b0 && (TIMEOUT == 0);
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    gap_d      = gap_q;
    win        = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    frame_d    = frame_q;
    block_d    = block_q & req;
    terr_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (|elig) begin
          if (elig == 2'b11) win = ~last_gnt_q;
          else               win = elig[1];
          owner_d    = win;
          last_gnt_d = win;
          state_d    = StOwn;
`ifdef SPI_ARB_TIMEOUT_EN
          frame_d    = 16'd0;
`endif
        end
      end
      StOwn: begin
        if (!req[owner_q]) state_d = StDrain;
      end
      StDrain: begin
        if (!br_busy && !br_rd_valid) begin
          state_d = StGap;
          gap_d   = GapInit;
        end
      end
      StGap: begin
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    if (state_q == StOwn || state_q == StDrain) begin
      frame_d = frame_q + 16'd1;
      if (frame_q == TimeoutLast) begin
        state_d          = StGap;
        gap_d            = GapInit;
        terr_d           = 1'b1;
        block_d[owner_q] = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      gap_q      <= GapInit;
`ifdef SPI_ARB_TIMEOUT_EN
      frame_q    <= 16'd0;
      block_q    <= 2'b00;
      terr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      gap_q      <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
      frame_q    <= frame_d;
      block_q    <= block_d;
      terr_q     <= terr_d;
`endif
    end
  end

  logic own, route_rd;

  assign own      = (state_q == StOwn);
  assign route_rd = (state_q == StOwn) || (state_q == StDrain);

  // Write path is only open in OWN; read-back keeps flowing to the owner while draining.
  always_comb begin
    br_cs       = ~route_rd;
    gnt0        = own & ~owner_q;
    gnt1        = own & owner_q;
    br_wr_valid = 1'b0;
    br_wr_data  = '0;
    br_rd_ready = 1'b0;
    m0_wr_ready = 1'b0;
    m1_wr_ready = 1'b0;
    m0_rd_valid = 1'b0;
    m1_rd_valid = 1'b0;
    m0_rd_data  = '0;
    m1_rd_data  = '0;
    if (own) begin
      br_wr_valid = owner_q ? m1_wr_valid : m0_wr_valid;
      br_wr_data  = owner_q ? m1_wr_data : m0_wr_data;
      m0_wr_ready = ~owner_q & br_wr_ready;
      m1_wr_ready = owner_q & br_wr_ready;
    end
    if (route_rd) begin
      br_rd_ready = owner_q ? m1_rd_ready : m0_rd_ready;
      if (owner_q) begin
        m1_rd_valid = br_rd_valid;
        m1_rd_data  = br_rd_data;
      end else begin
        m0_rd_valid = br_rd_valid;
        m0_rd_data  = br_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: scoreboard of expected bridge write words plus
// directed checks of grant, chip-select, gap, read-back hold and reset behaviour.
module tb_spi_bus_arbiter;
  localparam int unsigned DW      = 32;
  localparam int unsigned CS_GAP  = 4;
  localparam int unsigned TIMEOUT = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, m0_wr_valid, m0_wr_ready, m0_rd_valid, m0_rd_ready, gnt0;
  logic [DW-1:0] m0_wr_data, m0_rd_data;
  logic          req1, m1_wr_valid, m1_wr_ready, m1_rd_valid, m1_rd_ready, gnt1;
  logic [DW-1:0] m1_wr_data, m1_rd_data;
  logic          br_cs, br_wr_valid, br_wr_ready, br_rd_valid, br_rd_ready, br_busy;
  logic [DW-1:0] br_wr_data, br_rd_data;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int terr_cnt = 0;
  logic [32:0] sb[$];  // {port, word}

  spi_bus_arbiter #(.DW(DW), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .m0_wr_valid(m0_wr_valid), .m0_wr_data(m0_wr_data),
    .m0_wr_ready(m0_wr_ready), .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
    .m0_rd_ready(m0_rd_ready), .gnt0(gnt0),
    .req1(req1), .m1_wr_valid(m1_wr_valid), .m1_wr_data(m1_wr_data),
    .m1_wr_ready(m1_wr_ready), .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
    .m1_rd_ready(m1_rd_ready), .gnt1(gnt1),
    .br_cs(br_cs), .br_wr_valid(br_wr_valid), .br_wr_data(br_wr_data),
    .br_wr_ready(br_wr_ready), .br_rd_valid(br_rd_valid), .br_rd_data(br_rd_data),
    .br_rd_ready(br_rd_ready), .br_busy(br_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transfers happen on the next posedge; sample in the middle of the cycle.
  always @(negedge clk) begin
    if (!rst && timeout_err) terr_cnt++;
    if (!rst && br_wr_valid && br_wr_ready) begin
      if (sb.size() == 0) begin
        check("wr_unexpected_word", 32'(sb.size()), 32'd1);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("wr_data", br_wr_data, e[31:0]);
        check("wr_owner", {31'd0, gnt1}, {31'd0, e[32]});
      end
    end
  end

  task automatic send_word(input bit port, input logic [31:0] d);
    int  n = 0;
    logic rdy;
    if (port) begin m1_wr_valid = 1'b1; m1_wr_data = d; end
    else      begin m0_wr_valid = 1'b1; m0_wr_data = d; end
    sb.push_back({port, d});
    forever begin
      @(negedge clk);
      rdy = port ? m1_wr_ready : m0_wr_ready;
      if (rdy) break;
      n++;
      if (n > 50) begin
        check("wr_accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (port) m1_wr_valid = 1'b0;
    else      m0_wr_valid = 1'b0;
  endtask

  task automatic wait_gnt(input bit port, input string tag);
    int n = 0;
    while (((port ? gnt1 : gnt0) == 1'b0) && n < 40) begin
      cyc(1);
      n++;
    end
    check(tag, {31'd0, (port ? gnt1 : gnt0)}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req0 = 0; m0_wr_valid = 0; m0_wr_data = '0; m0_rd_ready = 0;
    req1 = 0; m1_wr_valid = 0; m1_wr_data = '0; m1_rd_ready = 0;
    br_wr_ready = 1; br_rd_valid = 0; br_rd_data = '0; br_busy = 0;
    #2;
    check("rst_br_cs", {31'd0, br_cs}, 32'd1);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_valids", {28'd0, br_wr_valid, br_rd_ready, m0_rd_valid, m1_rd_valid}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    cyc(3);
    rst = 1'b0;
    cyc(6);

    // Single requester, three words, drain with busy bridge, then measure CS gap.
    req0 = 1;
    cyc(1);
    check("t1_gnt0", {31'd0, gnt0}, 32'd1);
    check("t1_cs_low", {31'd0, br_cs}, 32'd0);
    send_word(0, 32'h1122_3344);
    send_word(0, 32'h5566_7788);
    send_word(0, 32'h99AA_BBCC);
    req0 = 0; br_busy = 1;
    cyc(1);
    check("t1_drain_gnt0", {31'd0, gnt0}, 32'd0);
    check("t1_drain_cs", {31'd0, br_cs}, 32'd0);
    cyc(2);
    check("t1_busy_cs", {31'd0, br_cs}, 32'd0);
    br_busy = 0;
    cyc(1);
    check("t1_gap_cs", {31'd0, br_cs}, 32'd1);
    req0 = 1;
    n = 1;
    while (br_cs && n < 30) begin cyc(1); n++; end
    check("t1_cs_gap_min", {31'd0, n >= int'(CS_GAP)}, 32'd1);
    check("t1_regrant", {31'd0, gnt0}, 32'd1);
    req0 = 0;
    cyc(8);

    // Simultaneous requests after reset: port 0 first, then port 1 while req0 re-asserts.
    rst = 1; cyc(2); rst = 0; cyc(6);
    req0 = 1; req1 = 1;
    m1_wr_valid = 1; m1_wr_data = 32'hDEAD_0001;
    cyc(1);
    check("t2_gnt0", {31'd0, gnt0}, 32'd1);
    check("t2_gnt1", {31'd0, gnt1}, 32'd0);
    check("t2_m1_ready_blocked", {31'd0, m1_wr_ready}, 32'd0);
    m1_wr_valid = 0;
    send_word(0, 32'h0000_0A01);
    send_word(0, 32'h0000_0A02);
    req0 = 0;
    cyc(1);
    req0 = 1;
    wait_gnt(1, "t2_rr_gnt1");
    check("t2_gnt0_while_req0", {31'd0, gnt0}, 32'd0);

    // Port 1 owns, port 0 has data pending: none of it may reach the bridge.
    m0_wr_valid = 1; m0_wr_data = 32'hBAD0_0000;
    #1;
    check("t3_m0_ready", {31'd0, m0_wr_ready}, 32'd0);
    send_word(1, 32'hCAFE_0001);
    check("t3_m0_ready_mid", {31'd0, m0_wr_ready}, 32'd0);
    send_word(1, 32'hCAFE_0002);
    m0_wr_valid = 0;

    // Read-back arrives during drain while the owner is not ready.
    req1 = 0;
    cyc(1);
    br_rd_valid = 1; br_rd_data = 32'hA5A5_A5A5; m1_rd_ready = 0;
    #1;
    check("t4_br_rd_ready", {31'd0, br_rd_ready}, 32'd0);
    check("t4_m1_rd_valid", {31'd0, m1_rd_valid}, 32'd1);
    check("t4_m1_rd_data", m1_rd_data, 32'hA5A5_A5A5);
    check("t4_m0_rd_valid", {31'd0, m0_rd_valid}, 32'd0);
    check("t4_m0_rd_data", m0_rd_data, 32'd0);
    repeat (3) begin
      cyc(1);
      check("t4_cs_held", {31'd0, br_cs}, 32'd0);
    end
    m1_rd_ready = 1;
    #1;
    check("t4_br_rd_ready_on", {31'd0, br_rd_ready}, 32'd1);
    cyc(1);
    br_rd_valid = 0; m1_rd_ready = 0;
    cyc(1);
    check("t4_cs_released", {31'd0, br_cs}, 32'd1);
    wait_gnt(0, "t4_gnt0_after_gap");

    // Asynchronous reset in the middle of word 2.
    send_word(0, 32'h0101_0101);
    br_wr_ready = 0; m0_wr_valid = 1; m0_wr_data = 32'h0202_0202;
    #2;
    rst = 1;
    #1;
    check("t5_cs", {31'd0, br_cs}, 32'd1);
    check("t5_gnt0", {31'd0, gnt0}, 32'd0);
    check("t5_valids", {29'd0, br_wr_valid, m0_wr_ready, br_rd_ready}, 32'd0);
    sb.delete();
    m0_wr_valid = 0; br_wr_ready = 1;
    cyc(2);
    rst = 0;
    n = 0;
    while (!gnt0 && n < 30) begin cyc(1); n++; end
    check("t5_gap_after_rst", {31'd0, n >= int'(CS_GAP)}, 32'd1);
    check("t5_regrant", {31'd0, gnt0}, 32'd1);
    req0 = 0;
    cyc(8);

`ifdef SPI_ARB_TIMEOUT_EN
    req1 = 1;
    wait_gnt(1, "to_gnt1");
    n = 0;
    while (!timeout_err && n < 200) begin cyc(1); n++; end
    check("to_cycles", 32'(n), 32'(TIMEOUT));
    check("to_cs", {31'd0, br_cs}, 32'd1);
    check("to_gnt1", {31'd0, gnt1}, 32'd0);
    cyc(1);
    check("to_pulse", {31'd0, timeout_err}, 32'd0);
    n = 0;
    repeat (20) begin cyc(1); if (gnt1) n++; end
    check("to_locked", 32'(n), 32'd0);
    req1 = 0; cyc(1); req1 = 1;
    wait_gnt(1, "to_regrant");
    req1 = 0;
    cyc(4);
    check("to_err_count", 32'(terr_cnt), 32'd1);
`else
    check("no_timeout_err", 32'(terr_cnt), 32'd0);
`endif
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single fifo2spi bridge (W5500 SPI master) between two 32-bit word streams.
  - Port 0: NIOS spiwr/spird FIFO path.
  - Port 1: hardware fast-path requester.
- Grants whole chip-select frames, round-robin.
- Muxes write and read-back streams to the owner of the current frame.
- Drives the bridge chip-select and enforces a minimum CS-high gap between frames.
- Sits between the kernel/hardware requesters and fifo2spi_bridge_top, replacing the direct nios_cs connection.

Parameters:
- DW, 32, data word width of all streams.
- CS_GAP, 4, minimum clk cycles br_cs stays high between frames (range 1..255).
- TIMEOUT, 65535, max cycles a frame may hold the bus (used only with SPI_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (100 MHz domain)
- rst  in  1  asynchronous reset, active-high
- req0  in  1  port 0 frame request; held high for the whole frame
- m0_wr_valid  in  1  port 0 write word valid
- m0_wr_data  in  DW  port 0 write word
- m0_wr_ready  out  1  port 0 write accept
- m0_rd_valid  out  1  port 0 read-back word valid
- m0_rd_data  out  DW  port 0 read-back word
- m0_rd_ready  in  1  port 0 read-back accept
- gnt0  out  1  port 0 owns the bus
- req1, m1_wr_valid, m1_wr_data, m1_wr_ready, m1_rd_valid, m1_rd_data, m1_rd_ready, gnt1: same as port 0, for port 1
- br_cs  out  1  bridge chip-select, active-low
- br_wr_valid  out  1  bridge write valid
- br_wr_data  out  DW  bridge write word
- br_wr_ready  in  1  bridge write accept
- br_rd_valid  in  1  bridge read-back valid
- br_rd_data  in  DW  bridge read-back word
- br_rd_ready  out  1  bridge read-back accept
- br_busy  in  1  bridge shifting or holding queued words
- timeout_err  out  1  one-cycle pulse when a frame is force-terminated

Behaviour:
- Reset values:
  - state=IDLE, owner=0, last_gnt=1 (port 0 wins first tie).
  - gap_cnt=CS_GAP.
  - br_cs=1, gnt0=gnt1=0, timeout_err=0.
  - All valid and ready outputs 0.
- FSM states: IDLE, OWN, DRAIN, GAP.
- IDLE:
  - Grant requires gap_cnt==0.
  - Only one req high: that port wins.
  - Both high: the port not equal to last_gnt wins.
  - Grant is registered: the cycle after the decision, owner and last_gnt are updated, gnt_owner=1, br_cs=0, state=OWN.
  - Latency from req to gnt/br_cs low is 1 cycle when gap_cnt is already 0.
- OWN:
  - Combinational routing: br_wr_valid/data = m_owner_wr_valid/data; m_owner_wr_ready = br_wr_ready.
  - Read-back: br_rd_ready = m_owner_rd_ready; m_owner_rd_valid/data = br_rd_valid/data.
  - Non-owner: wr_ready=0, rd_valid=0, rd_data=0.
  - req_owner low: go to DRAIN. gnt_owner drops next cycle; wr routing is blocked from DRAIN entry.
- DRAIN:
  - br_wr_valid=0; read-back still routed to owner.
  - br_cs stays 0 until br_busy==0 and br_rd_valid==0.
  - Then br_cs=1, gap_cnt=CS_GAP, state=GAP.
- GAP:
  - gap_cnt decrements to 0, then state=IDLE.
  - br_cs stays high for at least CS_GAP cycles.
  - Requests are not granted here; they stay pending.
- Boundary conditions:
  - req re-asserted by the owner during DRAIN or GAP is a new frame and arbitrates normally; round-robin applies, so the other port wins if it is pending.
  - Port 1 requesting while port 0 owns the bus: waits, with no preemption.
  - br_wr_ready is never combinationally forwarded to the non-owner.
  - Async rst mid-frame: all outputs return to reset values immediately; br_cs=1. Any partially sent frame is aborted and the bridge must resynchronise on CS high.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit frame counter clears on grant and increments in OWN and DRAIN.
  - Reaching TIMEOUT forces DRAIN→GAP: br_cs=1, gnt cleared, owner wr/rd streams blocked.
  - timeout_err pulses for 1 cycle.
  - The offending req must drop low before that port can be granted again.
- Undefined: no counter; timeout_err tied 0; a frame lasts as long as req is held.

Test Plan:
- req0 alone, 3 words 0x11223344.. with br_wr_ready=1 → gnt0 and br_cs=0 one cycle after req0; 3 words on br_wr_data in order; br_cs=1 after req0 drops and br_busy==0; cs high ≥4 cycles.
- req0 and req1 rise in the same cycle after reset → port 0 granted; after port 0's frame and the gap, port 1 granted while req0 is still high.
- Port 1 owns the bus, req0 asserts → m0_wr_ready stays 0 and br_wr_data never shows port 0 data until gnt0.
- Read-back 0xA5A5A5A5 arrives during DRAIN with m1_rd_ready=0 → br_rd_ready=0 and br_cs held low until m1_rd_ready=1 and the word is consumed.
- rst pulse mid-frame (word 2 of 4) → br_cs=1, gnt0=0, all valids 0 in the same cycle; after release, a new req0 is granted after the CS_GAP cycles elapse.
- SPI_ARB_TIMEOUT_EN with TIMEOUT=100, req1 held forever → timeout_err pulses at cycle 100, br_cs=1, and port 1 is not regranted until req1 toggles low.
